// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with NUM_READ_PORTS bypassed combinational reads, one write port, per-register pending scoreboard, debug tap and any-busy flag
module register_file_sb #(
  parameter int ADDRESS_WIDTH  = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_READ_PORTS = 2,
  parameter int DEBUG_REG      = 10
) (
  input  logic                                   iClk,
  input  logic                                   iRst,
  input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0] iReadAddress,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]    oRegData,
  output logic [NUM_READ_PORTS-1:0]               oBusy,
  input  logic                                   iWriteEn,
  input  logic [ADDRESS_WIDTH-1:0]               iWriteAddress,
  input  logic [DATA_WIDTH-1:0]                  iDataIn,
  input  logic                                   iIssueEn,
  input  logic [ADDRESS_WIDTH-1:0]               iIssueAddress,
  input  logic                                   iFlush,
  output logic [DATA_WIDTH-1:0]                  oDebugData,
  output logic                                   oAnyBusy
);
  localparam int DEPTH = 2**ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] DBG = ADDRESS_WIDTH'(DEBUG_REG);
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend, pend_n;
  always_comb begin
    pend_n = pend;
    if (iWriteEn) pend_n[iWriteAddress] = 1'b0;
    if (iIssueEn) pend_n[iIssueAddress] = 1'b1;
    if (iFlush) pend_n = '0;
    pend_n[0] = 1'b0;
  end
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      pend <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      pend <= pend_n;
      if (iWriteEn && iWriteAddress != '0) regs[iWriteAddress] <= iDataIn;
    end
  function automatic logic byp(input logic [ADDRESS_WIDTH-1:0] a);
    return iWriteEn && iWriteAddress == a;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] rd(input logic [ADDRESS_WIDTH-1:0] a);
    return (iRst || a == '0) ? '0 : byp(a) ? iDataIn : regs[a];
  endfunction
  function automatic logic bz(input logic [ADDRESS_WIDTH-1:0] a);
    return !iRst && a != '0 && !byp(a) && pend[a];
  endfunction
  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_rd
    assign oRegData[k*DATA_WIDTH +: DATA_WIDTH] = rd(iReadAddress[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
    assign oBusy[k] = bz(iReadAddress[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
  end
  assign oDebugData = rd(DBG);
  assign oAnyBusy = !iRst && |pend;
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: checks a 2x32 and a 4x64 register_file_sb against a bench model plus literal expectations
module tb_register_file_sb;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [19:0] raddr = '0;
  logic we = 1'b0, ie = 1'b0, fl = 1'b0;
  logic [4:0] wa = '0, ia = '0;
  logic [63:0] din = '0;
  logic [63:0] rd_a;
  logic [1:0] busy_a;
  logic [31:0] dbg_a;
  logic any_a;
  logic [255:0] rd_b;
  logic [3:0] busy_b;
  logic [63:0] dbg_b;
  logic any_b;
  register_file_sb #(.NUM_READ_PORTS(2)) u_a (
    .iClk(clk), .iRst(rst), .iReadAddress(raddr[9:0]), .oRegData(rd_a), .oBusy(busy_a),
    .iWriteEn(we), .iWriteAddress(wa), .iDataIn(din[31:0]), .iIssueEn(ie), .iIssueAddress(ia),
    .iFlush(fl), .oDebugData(dbg_a), .oAnyBusy(any_a));
  register_file_sb #(.NUM_READ_PORTS(4), .DATA_WIDTH(64)) u_b (
    .iClk(clk), .iRst(rst), .iReadAddress(raddr), .oRegData(rd_b), .oBusy(busy_b),
    .iWriteEn(we), .iWriteAddress(wa), .iDataIn(din), .iIssueEn(ie), .iIssueAddress(ia),
    .iFlush(fl), .oDebugData(dbg_b), .oAnyBusy(any_b));
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  logic [63:0] mr [32];
  logic [31:0] mp;
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 32; i++) mr[i] = '0;
      mp = '0;
    end else begin
      if (we && wa != 0) mr[wa] = din;
      for (int i = 1; i < 32; i++)
        if (fl) mp[i] = 1'b0;
        else if (ie && ia == i) mp[i] = 1'b1;
        else if (we && wa == i) mp[i] = 1'b0;
      mp[0] = 1'b0;
    end
  function automatic logic [63:0] m_rd(input logic [4:0] a);
    if (rst || a == 0) return '0;
    if (we && wa == a) return din;
    return mr[a];
  endfunction
  function automatic logic m_busy(input logic [4:0] a);
    return !rst && a != 0 && !(we && wa == a) && mp[a];
  endfunction
  always @(negedge clk) begin
    logic [63:0] e;
    logic [4:0] a;
    for (int k = 0; k < 4; k++) begin
      a = raddr[k*5 +: 5];
      e = m_rd(a);
      chk($sformatf("rd_b%0d", k), rd_b[k*64 +: 64], e);
      chk($sformatf("busy_b%0d", k), {63'd0, busy_b[k]}, {63'd0, m_busy(a)});
      if (k < 2) begin
        chk($sformatf("rd_a%0d", k), {32'd0, rd_a[k*32 +: 32]}, {32'd0, e[31:0]});
        chk($sformatf("busy_a%0d", k), {63'd0, busy_a[k]}, {63'd0, m_busy(a)});
      end
    end
    e = m_rd(5'd10);
    chk("dbg_b", dbg_b, e);
    chk("dbg_a", {32'd0, dbg_a}, {32'd0, e[31:0]});
    chk("any_a", {63'd0, any_a}, {63'd0, !rst && |mp});
    chk("any_b", {63'd0, any_b}, {63'd0, !rst && |mp});
  end
  task automatic cyc;
    @(posedge clk);
    #1;
    we = 1'b0; ie = 1'b0; fl = 1'b0;
  endtask
  initial begin
    we = 1'b1; wa = 5'd7; din = 64'h99; raddr = {5'd0, 5'd0, 5'd10, 5'd7};
    #3;
    chk("rst_rd", rd_a, 64'h0);
    chk("rst_rdb", rd_b, 64'h0);
    repeat (2) @(negedge clk);
    cyc; rst = 1'b0;
    cyc; we = 1'b1; wa = 5'd5; din = 64'hDEADBEEF;
    cyc; raddr = {5'd5, 5'd5, 5'd5, 5'd5};
    #2;
    chk("t1_p0", {32'd0, rd_a[31:0]}, 64'hDEADBEEF);
    chk("t1_p1", {32'd0, rd_a[63:32]}, 64'hDEADBEEF);
    chk("t1_b3", rd_b[255:192], 64'hDEADBEEF);
    cyc; we = 1'b1; wa = 5'd0; din = 64'h1234; raddr = {5'd0, 5'd0, 5'd0, 5'd0};
    cyc;
    #2;
    chk("t1_x0", {32'd0, rd_a[31:0]}, 64'h0);
    cyc; we = 1'b1; wa = 5'd7; din = 64'h55; raddr = {5'd0, 5'd0, 5'd7, 5'd0};
    #2;
    chk("t2_byp", {32'd0, rd_a[63:32]}, 64'h55);
    cyc; ie = 1'b1; ia = 5'd3; raddr = {5'd0, 5'd0, 5'd7, 5'd3};
    cyc;
    #2;
    chk("t3_busy", {63'd0, busy_a[0]}, 64'h1);
    chk("t3_x7", {32'd0, rd_a[63:32]}, 64'h55);
    cyc; we = 1'b1; wa = 5'd3; din = 64'h10;
    #2;
    chk("t3_wb_busy", {63'd0, busy_a[0]}, 64'h0);
    chk("t3_wb_rd", {32'd0, rd_a[31:0]}, 64'h10);
    cyc;
    #2;
    chk("t3_any", {63'd0, any_a}, 64'h0);
    cyc; ie = 1'b1; ia = 5'd9; we = 1'b1; wa = 5'd9; din = 64'hAA; raddr = {5'd0, 5'd0, 5'd0, 5'd9};
    cyc;
    #2;
    chk("t4_rd", {32'd0, rd_a[31:0]}, 64'hAA);
    chk("t4_busy", {63'd0, busy_a[0]}, 64'h1);
    cyc; we = 1'b1; wa = 5'd9; din = 64'hAA;
    cyc; ie = 1'b1; ia = 5'd0;
    cyc;
    #2;
    chk("t4_x0", {63'd0, any_a}, 64'h0);
    cyc; ie = 1'b1; ia = 5'd1;
    cyc; ie = 1'b1; ia = 5'd2;
    cyc; ie = 1'b1; ia = 5'd4;
    cyc;
    #2;
    chk("t5_any", {63'd0, any_a}, 64'h1);
    cyc; fl = 1'b1; we = 1'b1; wa = 5'd2; din = 64'h77; ie = 1'b1; ia = 5'd6;
    cyc; raddr = {5'd6, 5'd1, 5'd4, 5'd2};
    #2;
    chk("t5_flush_any", {63'd0, any_a}, 64'h0);
    chk("t5_x2", {32'd0, rd_a[31:0]}, 64'h77);
    chk("t5_busy_b", {60'd0, busy_b}, 64'h0);
    cyc; we = 1'b1; wa = 5'd10; din = 64'h0123_4567_0000_0042; ie = 1'b1; ia = 5'd10; raddr = {5'd10, 5'd10, 5'd10, 5'd10};
    #2;
    chk("t6_dbg_byp", {32'd0, dbg_a}, 64'h42);
    rst = 1'b1;
    #1;
    chk("t6_rst_dbg", dbg_b, 64'h0);
    chk("t6_rst_rd", rd_b[63:0], 64'h0);
    we = 1'b0; ie = 1'b0;
    #2;
    rst = 1'b0;
    cyc;
    #2;
    chk("t6_dbg_a", {32'd0, dbg_a}, 64'h0);
    chk("t6_dbg_b", dbg_b, 64'h0);
    chk("t6_busy", {60'd0, busy_b}, 64'h0);
    for (int n = 0; n < 60; n++) begin
      cyc;
      we = 1'($urandom); wa = 5'($urandom); din = {$urandom, $urandom};
      ie = 1'($urandom); ia = 5'($urandom); fl = ($urandom_range(0, 9) == 0);
      raddr = 20'($urandom);
    end
    cyc;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
